// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if
// Bundles the pipeline-facing signals of the multiply/divide unit.
//   E-stage inputs : EOpcode, EFunct, EValid, A (rs), B (rt)
//   D-stage inputs : DOpcode, DFunct
//   Outputs        : Start (accept pulse), Busy (op in flight), Stall (hold D),
//                    MDOut (MFHI/MFLO read data), HI, LO (architectural regs)
// master : pipeline side (drives instructions/operands)
// slave  : multiply/divide unit
interface md_unit_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       EOpcode;
  logic [5:0]       EFunct;
  logic             EValid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [5:0]       DOpcode;
  logic [5:0]       DFunct;
  logic             Start;
  logic             Busy;
  logic             Stall;
  logic [WIDTH-1:0] MDOut;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output EOpcode, EFunct, EValid, A, B, DOpcode, DFunct,
    input  Start, Busy, Stall, MDOut, HI, LO
  );

  modport slave (
    input  EOpcode, EFunct, EValid, A, B, DOpcode, DFunct,
    output Start, Busy, Stall, MDOut, HI, LO
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl
// Multiply/divide unit with HI/LO registers, a latency counter and D-stage
// stall generation. Sits beside the E-stage ALU.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears HI/LO, counter, pending result
//   bus   : md_unit_ctrl_if.slave (E/D decode inputs, operands, Start, Busy,
//           Stall, MDOut, HI, LO)
// The result is computed in the accept cycle and parked in pending registers;
// HI/LO are only updated after the configured latency has elapsed.
module md_unit_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic         clk,
  input logic         reset,
  md_unit_ctrl_if.slave bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic [WIDTH-1:0] hi_q, lo_q;

  // ---------------- decode ----------------
  logic e_rtype, e_mult, e_multu, e_div, e_divu, e_mfhi, e_mflo, e_mthi, e_mtlo;
  logic e_muldiv, d_md;

  always_comb begin
    e_rtype  = (bus.EOpcode == 6'b000000);
    e_mult   = e_rtype && (bus.EFunct == F_MULT);
    e_multu  = e_rtype && (bus.EFunct == F_MULTU);
    e_div    = e_rtype && (bus.EFunct == F_DIV);
    e_divu   = e_rtype && (bus.EFunct == F_DIVU);
    e_mfhi   = e_rtype && (bus.EFunct == F_MFHI);
    e_mflo   = e_rtype && (bus.EFunct == F_MFLO);
    e_mthi   = e_rtype && (bus.EFunct == F_MTHI);
    e_mtlo   = e_rtype && (bus.EFunct == F_MTLO);
    e_muldiv = e_mult || e_multu || e_div || e_divu;
    d_md     = (bus.DOpcode == 6'b000000) &&
               (bus.DFunct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                   F_MULT, F_MULTU, F_DIV, F_DIVU});
  end

  // ---------------- control ----------------
  logic busy, start, done;

  assign busy = (state == S_BUSY);
  // Start and Stall are forced low while reset is held so nothing downstream
  // sees an accept that the (held-in-reset) registers cannot honour.
  assign start = reset && bus.EValid && e_muldiv && !busy;
  assign done  = busy && (cnt <= CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_BUSY;
      S_BUSY: if (done)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- arithmetic ----------------
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag;
  logic [WIDTH-1:0]   q_s, r_s, q_u, r_u;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod_s = {{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
    prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

    // Signed divide via magnitudes: quotient sign is the XOR of operand signs,
    // remainder follows the dividend. Most-negative / -1 falls out naturally:
    // the magnitude quotient 2^(W-1) reinterprets as the most-negative value.
    a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
    b_mag = bus.B[WIDTH-1] ? -bus.B : bus.B;
    q_mag = '0;
    r_mag = '0;
    q_u   = '0;
    r_u   = '0;
    if (bus.B != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      q_u   = bus.A / bus.B;
      r_u   = bus.A % bus.B;
    end
    q_s = (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) ? -q_mag : q_mag;
    r_s = bus.A[WIDTH-1] ? -r_mag : r_mag;

    res_hi = '0;
    res_lo = '0;
    if (e_mult) begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end else if (e_multu) begin
      res_hi = prod_u[2*WIDTH-1:WIDTH];
      res_lo = prod_u[WIDTH-1:0];
    end else if (e_div || e_divu) begin
      if (bus.B == '0) begin
        res_hi = bus.A;
        res_lo = '1;
      end else if (e_div) begin
        res_hi = r_s;
        res_lo = q_s;
      end else begin
        res_hi = r_u;
        res_lo = q_u;
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      if (start) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        cnt     <= (e_div || e_divu) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (busy && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (done) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end else if (bus.EValid && !busy) begin
        if (e_mthi) hi_q <= bus.A;
        if (e_mtlo) lo_q <= bus.A;
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.Start = start;
    bus.Busy  = busy;
    bus.Stall = reset && (busy || start) && d_md;
    bus.HI    = hi_q;
    bus.LO    = lo_q;
    bus.MDOut = '0;
    if (e_mfhi)      bus.MDOut = hi_q;
    else if (e_mflo) bus.MDOut = lo_q;
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl
// Directed bench for md_unit_ctrl: reset state, MULT latency and stall,
// DIVU/DIV/MULTU results, divide-by-zero and overflow corner cases, ignored
// MD ops while busy, MTHI/MTLO/MFHI/MFLO, and reset mid-operation.
module tb_md_unit_ctrl;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU  = 6'b100001;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  md_unit_ctrl_if #(.WIDTH(32)) bus ();

  md_unit_ctrl #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic [5:0] funct, input logic valid,
                       input logic [31:0] a, input logic [31:0] b);
    bus.EOpcode = 6'b000000;
    bus.EFunct  = funct;
    bus.EValid  = valid;
    bus.A       = a;
    bus.B       = b;
  endtask

  task automatic bubble();
    set_e(6'b000000, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic set_d(input logic [5:0] funct);
    bus.DOpcode = 6'b000000;
    bus.DFunct  = funct;
  endtask

  // Issue a mult/div, check Start, Busy for n cycles, then the HI/LO result.
  task automatic run_md(input string tag, input logic [5:0] funct,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    set_e(funct, 1'b1, a, b);
    #1;
    chk({tag, "_start"}, {31'b0, bus.Start}, 32'd1);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == 1) bubble();
      #1;
      chk({tag, "_busy"}, {31'b0, bus.Busy}, 32'd1);
    end
    tick();
    #1;
    chk({tag, "_idle"}, {31'b0, bus.Busy}, 32'd0);
    chk({tag, "_hi"}, bus.HI, exp_hi);
    chk({tag, "_lo"}, bus.LO, exp_lo);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    set_e(F_MULT, 1'b1, 32'd3, 32'd4);
    set_d(F_MFLO);

    // Reset state, with a MULT in E and MFLO in D held off by reset.
    tick();
    tick();
    #1;
    chk("rst_hi",    bus.HI, 32'h0);
    chk("rst_lo",    bus.LO, 32'h0);
    chk("rst_busy",  {31'b0, bus.Busy},  32'd0);
    chk("rst_start", {31'b0, bus.Start}, 32'd0);
    chk("rst_stall", {31'b0, bus.Stall}, 32'd0);
    bubble();
    reset = 1'b1;

    // MULT 3 * -2 with MFLO waiting in D.
    tick();
    set_e(F_MULT, 1'b1, 32'd3, 32'hFFFF_FFFE);
    set_d(F_MFLO);
    #1;
    chk("mult_t0_start", {31'b0, bus.Start}, 32'd1);
    chk("mult_t0_busy",  {31'b0, bus.Busy},  32'd0);
    chk("mult_t0_stall", {31'b0, bus.Stall}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) bubble();
      #1;
      chk("mult_busy",  {31'b0, bus.Busy},  32'd1);
      chk("mult_stall", {31'b0, bus.Stall}, 32'd1);
      chk("mult_start", {31'b0, bus.Start}, 32'd0);
    end
    tick();
    #1;
    chk("mult_t6_busy",  {31'b0, bus.Busy},  32'd0);
    chk("mult_t6_stall", {31'b0, bus.Stall}, 32'd0);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
    // MFLO advances into E.
    set_e(F_MFLO, 1'b1, 32'h0, 32'h0);
    set_d(F_ADDU);
    #1;
    chk("mflo_out", bus.MDOut, 32'hFFFF_FFFA);
    chk("mflo_start", {31'b0, bus.Start}, 32'd0);

    // DIVU 7/2 with ADDU in D; MD ops forced into E while busy are ignored.
    tick();
    set_e(F_DIVU, 1'b1, 32'd7, 32'd2);
    set_d(F_ADDU);
    #1;
    chk("divu_start", {31'b0, bus.Start}, 32'd1);
    chk("divu_stall_t0", {31'b0, bus.Stall}, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 2) set_e(F_MULT, 1'b1, 32'd9, 32'd9);
      else if (i == 3) set_e(F_MTHI, 1'b1, 32'hDEAD_BEEF, 32'h0);
      else if (i == 4) set_e(F_MTLO, 1'b1, 32'hDEAD_BEEF, 32'h0);
      else bubble();
      #1;
      chk("divu_busy",  {31'b0, bus.Busy},  32'd1);
      chk("divu_stall", {31'b0, bus.Stall}, 32'd0);
      if (i == 2) chk("busy_ignore_start", {31'b0, bus.Start}, 32'd0);
      if (i == 5) chk("busy_ignore_hi", bus.HI, 32'hFFFF_FFFF);
      if (i == 5) chk("busy_ignore_lo", bus.LO, 32'hFFFF_FFFA);
    end
    tick();
    #1;
    chk("divu_idle", {31'b0, bus.Busy}, 32'd0);
    chk("divu_hi", bus.HI, 32'd1);
    chk("divu_lo", bus.LO, 32'd3);

    // Remaining arithmetic cases.
    run_md("div_neg",  F_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_zero", F_DIV,   32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF);
    run_md("divu_zero",F_DIVU,  32'h8000_0001, 32'd0,         10, 32'h8000_0001, 32'hFFFF_FFFF);
    run_md("div_ovf",  F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0,         32'h8000_0000);
    run_md("div_mix",  F_DIV,   32'd100,       32'hFFFF_FFF9, 10, 32'd2,         32'hFFFF_FFF2);
    run_md("multu",    F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    run_md("mult_mn",  F_MULT,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0);

    // MTHI then MFHI; MTLO; MTHI in an invalid slot has no effect.
    set_e(F_MTHI, 1'b1, 32'h1234_5678, 32'h0);
    set_d(F_MFHI);
    #1;
    chk("mthi_stall", {31'b0, bus.Stall}, 32'd0);
    chk("mthi_start", {31'b0, bus.Start}, 32'd0);
    tick();
    set_e(F_MFHI, 1'b1, 32'h0, 32'h0);
    set_d(F_ADDU);
    #1;
    chk("mthi_hi",   bus.HI, 32'h1234_5678);
    chk("mfhi_out",  bus.MDOut, 32'h1234_5678);
    chk("mthi_busy", {31'b0, bus.Busy}, 32'd0);
    tick();
    set_e(F_MTLO, 1'b1, 32'hCAFE_F00D, 32'h0);
    tick();
    set_e(F_MTHI, 1'b0, 32'h0BAD_0BAD, 32'h0);
    #1;
    chk("mtlo_lo", bus.LO, 32'hCAFE_F00D);
    tick();
    bubble();
    #1;
    chk("mthi_invalid_hi", bus.HI, 32'h1234_5678);

    // DIV aborted by reset at t4; nothing lands after release.
    set_e(F_DIV, 1'b1, 32'd100, 32'd7);
    set_d(F_ADDU);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) bubble();
    end
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, bus.Busy}, 32'd0);
    chk("abort_hi",   bus.HI, 32'h0);
    chk("abort_lo",   bus.LO, 32'h0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    #1;
    chk("abort_after_busy", {31'b0, bus.Busy}, 32'd0);
    chk("abort_after_hi",   bus.HI, 32'h0);
    chk("abort_after_lo",   bus.LO, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
